// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ctrl_pkg
//  Description : Shared encodings for the fetch/execute control sequencer:
//                FSM state codes, instruction classes, control sub-ops and
//                the set of instructions that carry an immediate byte.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_IMM   = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    // Instruction classes, ir[7:6]
    localparam logic [1:0] CLS_MOV = 2'b00;
    localparam logic [1:0] CLS_LDI = 2'b01;
    localparam logic [1:0] CLS_ALU = 2'b10;
    localparam logic [1:0] CLS_CTL = 2'b11;

    // Control-class sub-ops, ir[5:3]
    localparam logic [2:0] CTL_JMP = 3'b000;
    localparam logic [2:0] CTL_JZ  = 3'b001;
    localparam logic [2:0] CTL_HLT = 3'b111;

    // One bit per class / per control sub-op: set when a second byte follows
    localparam logic [3:0] NEEDS_IMM_CLS = 4'b0010;      // LDI only
    localparam logic [7:0] NEEDS_IMM_CTL = 8'b0000_0011; // JMP and JZ

    function automatic logic needs_imm(input logic [7:0] instr);
        logic w_cls_hit;
        logic w_ctl_hit;
        w_cls_hit = NEEDS_IMM_CLS[instr[7:6]];
        w_ctl_hit = (instr[7:6] == CLS_CTL) && NEEDS_IMM_CTL[instr[5:3]];
        return w_cls_hit | w_ctl_hit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decoder
//  Description : Purely combinational instruction byte decoder. Splits the
//                byte into class / fields and flags each instruction kind.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_decoder #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] HLT_CODE = 8'hFF
) (
    input  logic [WIDTH-1:0] instr_i,
    output logic             needs_imm_o,
    output logic             is_mov_o,
    output logic             is_ldi_o,
    output logic             is_alu_o,
    output logic             is_jmp_o,
    output logic             is_jz_o,
    output logic             is_hlt_o,
    output logic [2:0]       fa_o,
    output logic [2:0]       fb_o
);
    import ctrl_pkg::*;

    logic [1:0] w_cls;

    assign w_cls = instr_i[7:6];
    assign fa_o  = instr_i[5:3];
    assign fb_o  = instr_i[2:0];

    assign needs_imm_o = needs_imm(instr_i);
    assign is_mov_o    = (w_cls == CLS_MOV);
    assign is_ldi_o    = (w_cls == CLS_LDI);
    assign is_alu_o    = (w_cls == CLS_ALU);
    assign is_jmp_o    = (w_cls == CLS_CTL) && (fa_o == CTL_JMP);
    assign is_jz_o     = (w_cls == CLS_CTL) && (fa_o == CTL_JZ);
    // Only the exact halt byte halts; other A=111 control bytes are NOPs
    assign is_hlt_o    = (w_cls == CLS_CTL) && (fa_o == CTL_HLT) && (instr_i == HLT_CODE);

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer
//  Description : Fetch/execute control FSM for the 8-bit datapath. Sequences
//                PC, register block and ALU enables from the instruction
//                stream on bus_in. Only WIDTH = 8 is supported.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] HLT_CODE = 8'hFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             alu_zero,
    output logic             pc_oe,
    output logic             pc_inc,
    output logic             pc_set,
    output logic             reg_we,
    output logic             reg_oe,
    output logic [2:0]       reg_iaddr,
    output logic [2:0]       reg_oaddr,
    output logic             imm_oe,
    output logic [WIDTH-1:0] imm_out,
    output logic [2:0]       alu_op,
    output logic             alu_oe,
    output logic             halted
);
    import ctrl_pkg::*;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] imm_q, imm_d;
    logic             zflag_q, zflag_d;

    // Decode of the incoming byte: only needs_imm steers the next state
    logic       w_bus_needs_imm;
    logic       w_bus_unused_mov, w_bus_unused_ldi, w_bus_unused_alu;
    logic       w_bus_unused_jmp, w_bus_unused_jz, w_bus_unused_hlt;
    logic [2:0] w_bus_unused_fa, w_bus_unused_fb;

    // Decode of the latched instruction: drives EXEC outputs
    logic       w_ir_unused_needs_imm;
    logic       w_ir_is_mov, w_ir_is_ldi, w_ir_is_alu;
    logic       w_ir_is_jmp, w_ir_is_jz, w_ir_is_hlt;
    logic [2:0] w_ir_fa, w_ir_fb;

    instr_decoder #(.WIDTH(WIDTH), .HLT_CODE(HLT_CODE)) u_dec_bus (
        .instr_i     (bus_in),
        .needs_imm_o (w_bus_needs_imm),
        .is_mov_o    (w_bus_unused_mov),
        .is_ldi_o    (w_bus_unused_ldi),
        .is_alu_o    (w_bus_unused_alu),
        .is_jmp_o    (w_bus_unused_jmp),
        .is_jz_o     (w_bus_unused_jz),
        .is_hlt_o    (w_bus_unused_hlt),
        .fa_o        (w_bus_unused_fa),
        .fb_o        (w_bus_unused_fb)
    );

    instr_decoder #(.WIDTH(WIDTH), .HLT_CODE(HLT_CODE)) u_dec_ir (
        .instr_i     (ir_q),
        .needs_imm_o (w_ir_unused_needs_imm),
        .is_mov_o    (w_ir_is_mov),
        .is_ldi_o    (w_ir_is_ldi),
        .is_alu_o    (w_ir_is_alu),
        .is_jmp_o    (w_ir_is_jmp),
        .is_jz_o     (w_ir_is_jz),
        .is_hlt_o    (w_ir_is_hlt),
        .fa_o        (w_ir_fa),
        .fb_o        (w_ir_fb)
    );

    // Next-state and datapath-register update logic
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        imm_d   = imm_q;
        zflag_d = zflag_q;
        case (state_q)
            ST_FETCH: begin
                ir_d    = bus_in;
                state_d = w_bus_needs_imm ? ST_IMM : ST_EXEC;
            end
            ST_IMM: begin
                imm_d   = bus_in;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (w_ir_is_alu) begin
                    zflag_d = alu_zero;
                end
                state_d = w_ir_is_hlt ? ST_HALT : ST_FETCH;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            ir_q    <= '0;
            imm_q   <= '0;
            zflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            imm_q   <= imm_d;
            zflag_q <= zflag_d;
        end
    end

    assign imm_out = imm_q;

    // Moore output decode from (state, ir); reset forces every enable low
    always_comb begin
        pc_oe     = 1'b0;
        pc_inc    = 1'b0;
        pc_set    = 1'b0;
        reg_we    = 1'b0;
        reg_oe    = 1'b0;
        reg_iaddr = 3'd0;
        reg_oaddr = 3'd0;
        imm_oe    = 1'b0;
        alu_op    = 3'd0;
        alu_oe    = 1'b0;
        halted    = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_FETCH, ST_IMM: begin
                    pc_oe  = 1'b1;
                    pc_inc = 1'b1;
                end
                ST_EXEC: begin
                    if (w_ir_is_mov) begin
                        reg_oe    = 1'b1;
                        reg_oaddr = w_ir_fb;
                        reg_we    = 1'b1;
                        reg_iaddr = w_ir_fa;
                    end else if (w_ir_is_ldi) begin
                        imm_oe    = 1'b1;
                        reg_we    = 1'b1;
                        reg_iaddr = w_ir_fa;
                    end else if (w_ir_is_alu) begin
                        alu_op    = w_ir_fa;
                        alu_oe    = 1'b1;
                        reg_we    = 1'b1;
                        reg_iaddr = w_ir_fb;
                    end else if (w_ir_is_jmp) begin
                        imm_oe    = 1'b1;
                        pc_set    = 1'b1;
                    end else if (w_ir_is_jz) begin
                        imm_oe    = zflag_q;
                        pc_set    = zflag_q;
                    end
                end
                ST_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    halted = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_sequencer
//  Description : Self-checking bench: directed vector table for the listed
//                scenarios, then a random instruction stream compared against
//                an instruction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] bus_in;
    logic       alu_zero;
    logic       pc_oe, pc_inc, pc_set, reg_we, reg_oe, imm_oe, alu_oe, halted;
    logic [2:0] reg_iaddr, reg_oaddr, alu_op;
    logic [7:0] imm_out;

    always #5 clk = ~clk;

    control_sequencer #(.WIDTH(8), .HLT_CODE(8'hFF)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus_in    (bus_in),
        .alu_zero  (alu_zero),
        .pc_oe     (pc_oe),
        .pc_inc    (pc_inc),
        .pc_set    (pc_set),
        .reg_we    (reg_we),
        .reg_oe    (reg_oe),
        .reg_iaddr (reg_iaddr),
        .reg_oaddr (reg_oaddr),
        .imm_oe    (imm_oe),
        .imm_out   (imm_out),
        .alu_op    (alu_op),
        .alu_oe    (alu_oe),
        .halted    (halted)
    );

    // Packed view of every output, in a fixed order
    logic [24:0] act;
    assign act = {pc_oe, pc_inc, pc_set, reg_we, reg_oe, reg_iaddr, reg_oaddr,
                  imm_oe, imm_out, alu_op, alu_oe, halted};

    function automatic logic [24:0] pk(input logic p_oe, input logic p_inc, input logic p_set,
                                       input logic r_we, input logic r_oe,
                                       input logic [2:0] ia, input logic [2:0] oa,
                                       input logic i_oe, input logic [7:0] imm,
                                       input logic [2:0] op, input logic a_oe, input logic hlt);
        return {p_oe, p_inc, p_set, r_we, r_oe, ia, oa, i_oe, imm, op, a_oe, hlt};
    endfunction

    function automatic logic [24:0] e_fetch(input logic [7:0] imm);
        return pk(1, 1, 0, 0, 0, 3'd0, 3'd0, 0, imm, 3'd0, 0, 0);
    endfunction
    function automatic logic [24:0] e_idle(input logic [7:0] imm);
        return pk(0, 0, 0, 0, 0, 3'd0, 3'd0, 0, imm, 3'd0, 0, 0);
    endfunction
    function automatic logic [24:0] e_halt(input logic [7:0] imm);
        return pk(0, 0, 0, 0, 0, 3'd0, 3'd0, 0, imm, 3'd0, 0, 1);
    endfunction

    int checks = 0;
    int errors = 0;

    // ---------------- reference model: instruction-level view ----------------
    logic       m_halt = 1'b0;
    logic       m_z    = 1'b0;
    logic [7:0] m_imm  = 8'h00;
    logic [7:0] m_ir   = 8'h00;
    int         m_cyc  = 0;   // cycles spent so far on the current instruction

    // Instruction length in bytes: LDI, JMP and JZ carry an immediate
    function automatic int ilen(input logic [7:0] b);
        if (b[7:6] == 2'b01) return 2;
        if (b[7:6] == 2'b11 && (b[5:3] == 3'd0 || b[5:3] == 3'd1)) return 2;
        return 1;
    endfunction

    function automatic logic [24:0] model_exp(input logic r);
        logic [2:0] a;
        logic [2:0] b;
        a = m_ir[5:3];
        b = m_ir[2:0];
        if (r) return e_idle(m_imm);
        if (m_halt) return e_halt(m_imm);
        if (m_cyc == 0 || m_cyc < ilen(m_ir)) return e_fetch(m_imm);
        case (m_ir[7:6])
            2'b00:   return pk(0, 0, 0, 1, 1, a, b, 0, m_imm, 3'd0, 0, 0);
            2'b01:   return pk(0, 0, 0, 1, 0, a, 3'd0, 1, m_imm, 3'd0, 0, 0);
            2'b10:   return pk(0, 0, 0, 1, 0, b, 3'd0, 0, m_imm, a, 1, 0);
            default: begin
                if (a == 3'd0) return pk(0, 0, 1, 0, 0, 3'd0, 3'd0, 1, m_imm, 3'd0, 0, 0);
                if (a == 3'd1) return pk(0, 0, m_z, 0, 0, 3'd0, 3'd0, m_z, m_imm, 3'd0, 0, 0);
                return e_idle(m_imm);
            end
        endcase
    endfunction

    task automatic model_step(input logic r, input logic [7:0] b, input logic z);
        if (r) begin
            m_halt = 1'b0; m_ir = 8'h00; m_imm = 8'h00; m_z = 1'b0; m_cyc = 0;
        end else if (m_halt) begin
            m_cyc = 0;
        end else if (m_cyc == 0) begin
            m_ir  = b;
            m_cyc = 1;
        end else if (m_cyc < ilen(m_ir)) begin
            m_imm = b;
            m_cyc = m_cyc + 1;
        end else begin
            if (m_ir[7:6] == 2'b10) m_z = z;
            if (m_ir == 8'hFF) m_halt = 1'b1;
            m_cyc = 0;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [24:0] got, input logic [24:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (pc_oe,pc_inc,pc_set,we,roe,ia,oa,imm_oe,imm,op,alu_oe,hlt)",
                     nm, got, exp);
        end
    endtask

    task automatic chk_excl(input string nm);
        checks++;
        if ((int'(reg_oe) + int'(imm_oe) + int'(alu_oe)) > 1 || (pc_inc && pc_set)) begin
            errors++;
            $display("FAIL %s exclusivity got oe=%b%b%b inc/set=%b%b required at most one",
                     nm, reg_oe, imm_oe, alu_oe, pc_inc, pc_set);
        end
    endtask

    // Apply one cycle of inputs, check outputs, then advance DUT and model
    task automatic run_cycle(input logic r, input logic [7:0] b, input logic z,
                             input logic [24:0] exp, input string nm);
        reset    = r;
        bus_in   = b;
        alu_zero = z;
        #1;
        chk(nm, act, exp);
        chk_excl(nm);
        @(posedge clk);
        model_step(r, b, z);
        @(negedge clk);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        logic [7:0]  bus;
        logic        az;
        logic [24:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [7:0] b, input logic z, input logic [24:0] e);
        vec_t v;
        v.rst = r; v.bus = b; v.az = z; v.exp = e;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        bus_in   = 8'h00;
        alu_zero = 1'b0;
        @(posedge clk);
        model_step(1'b1, 8'h00, 1'b0);
        @(negedge clk);

        add(1, 8'h00, 0, e_idle(8'h00));                                   // reset state
        add(0, 8'h0A, 0, e_fetch(8'h00));                                  // MOV 1<-2
        add(0, 8'h00, 0, pk(0,0,0,1,1,3'd1,3'd2,0,8'h00,3'd0,0,0));
        add(0, 8'h58, 0, e_fetch(8'h00));                                  // LDI r3
        add(0, 8'h3C, 0, e_fetch(8'h00));
        add(0, 8'h00, 0, pk(0,0,0,1,0,3'd3,3'd0,1,8'h3C,3'd0,0,0));
        add(0, 8'h95, 0, e_fetch(8'h3C));                                  // ALU op2 dst5, z=1
        add(0, 8'h00, 1, pk(0,0,0,1,0,3'd5,3'd0,0,8'h3C,3'd2,1,0));
        add(0, 8'hC8, 0, e_fetch(8'h3C));                                  // JZ taken
        add(0, 8'h40, 0, e_fetch(8'h3C));
        add(0, 8'h00, 0, pk(0,0,1,0,0,3'd0,3'd0,1,8'h40,3'd0,0,0));
        add(0, 8'h95, 1, e_fetch(8'h40));                                  // ALU, z=0
        add(0, 8'h00, 0, pk(0,0,0,1,0,3'd5,3'd0,0,8'h40,3'd2,1,0));
        add(0, 8'hC8, 0, e_fetch(8'h40));                                  // JZ not taken
        add(0, 8'h44, 0, e_fetch(8'h40));
        add(0, 8'h00, 0, e_idle(8'h44));
        add(0, 8'hC0, 0, e_fetch(8'h44));                                  // JMP
        add(0, 8'h10, 0, e_fetch(8'h44));
        add(0, 8'h00, 0, pk(0,0,1,0,0,3'd0,3'd0,1,8'h10,3'd0,0,0));
        add(0, 8'hD0, 0, e_fetch(8'h10));                                  // NOP
        add(0, 8'h00, 0, e_idle(8'h10));
        add(0, 8'h09, 0, e_fetch(8'h10));                                  // MOV 1<-1
        add(0, 8'h00, 0, pk(0,0,0,1,1,3'd1,3'd1,0,8'h10,3'd0,0,0));
        add(0, 8'h95, 0, e_fetch(8'h10));                                  // ALU, z=1
        add(0, 8'h00, 1, pk(0,0,0,1,0,3'd5,3'd0,0,8'h10,3'd2,1,0));
        add(0, 8'hFF, 0, e_fetch(8'h10));                                  // HLT
        add(0, 8'h00, 0, e_idle(8'h10));
        for (int k = 0; k < 12; k++) begin
            add(0, 8'(k * 37 + 10), k[0], e_halt(8'h10));
        end
        add(1, 8'h58, 0, e_idle(8'h10));                                   // reset out of HALT
        add(0, 8'h58, 0, e_fetch(8'h00));                                  // LDI, reset in IMM
        add(1, 8'h77, 0, e_idle(8'h00));
        add(0, 8'hC8, 0, e_fetch(8'h00));                                  // JZ: zflag cleared
        add(0, 8'h55, 0, e_fetch(8'h00));
        add(0, 8'h00, 0, e_idle(8'h55));
        add(0, 8'h0A, 0, e_fetch(8'h55));

        for (int i = 0; i < tbl.size(); i++) begin
            run_cycle(tbl[i].rst, tbl[i].bus, tbl[i].az, tbl[i].exp, $sformatf("vec%0d", i));
        end

        // ---------------- random instruction stream vs model ----------------
        run_cycle(1'b1, 8'h00, 1'b0, model_exp(1'b1), "rnd_reset");
        for (int n = 0; n < 1500; n++) begin
            logic       r;
            logic [7:0] b;
            logic       z;
            r = ($urandom_range(0, 99) < 2);
            b = 8'($urandom);
            if (b == 8'hFF && $urandom_range(0, 3) != 0) b = 8'hFE;
            z = 1'($urandom);
            run_cycle(r, b, z, model_exp(r), $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
